sig_dump: RTL and testbench

SIG_DUMP -- requirements
Module: sig_dump

---
 rtl/sig_dump.sv | 143 ++++++++++++++
 tb/tb_sig_dump.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_dump.sv
// sig_dump: register-programmed engine that reads RAM words BEGIN..END over the host bus and streams them out as a signature
module sig_dump #(
    parameter int AddrWinBits = 10,
    parameter int MaxWords    = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [31:0] dev_wdata_i,
    input  logic [3:0]  dev_be_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        sig_valid_o,
    input  logic        sig_ready_i,
    output logic [31:0] sig_data_o,
    output logic        sig_last_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int OffBits = AddrWinBits - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

    state_t             state, state_nx;
    logic [31:0]        beg_addr, end_addr, ptr, count, data;
    logic               done, err;
    logic [OffBits-1:0] off;
    logic               sel_beg, sel_end, sel_ctrl, sel_stat, sel_cnt;
    logic               acc_err, wr_ok, start, run_ok, fire, last;
    logic [31:0]        wmask, rd_mux, beg_aln;
    logic               unused_addr;

    assign unused_addr = ^{dev_addr_i[31:AddrWinBits], dev_addr_i[1:0]};

    assign off      = dev_addr_i[AddrWinBits-1:2];
    assign sel_beg  = off == OffBits'(0);
    assign sel_end  = off == OffBits'(1);
    assign sel_ctrl = off == OffBits'(2);
    assign sel_stat = off == OffBits'(3);
    assign sel_cnt  = off == OffBits'(4);

    // Unmapped offsets, writes to read-only regs, reads of CTRL and reprogramming mid-run are rejected
    assign acc_err = ~(sel_beg | sel_end | sel_ctrl | sel_stat | sel_cnt)
                   | (dev_we_i & (sel_stat | sel_cnt))
                   | (~dev_we_i & sel_ctrl)
                   | (dev_we_i & busy_o & (sel_beg | sel_end | sel_ctrl));
    assign wr_ok   = dev_req_i & dev_we_i & ~acc_err;
    assign start   = wr_ok & sel_ctrl & dev_be_i[0] & dev_wdata_i[0];
    assign wmask   = {{8{dev_be_i[3]}}, {8{dev_be_i[2]}}, {8{dev_be_i[1]}}, {8{dev_be_i[0]}}};
    assign beg_aln = {beg_addr[31:2], 2'b00};
    assign run_ok  = beg_aln < end_addr;
    assign rd_mux  = sel_beg  ? beg_addr :
                     sel_end  ? end_addr :
                     sel_stat ? {29'b0, err, done, busy_o} :
                     sel_cnt  ? count : '0;

    // Last beat when the next word would reach END (33-bit to avoid wrap) or the word budget is spent
    assign last   = ({1'b0, ptr} + 33'd4 >= {1'b0, end_addr}) | (count + 32'd1 == 32'(MaxWords));
    assign fire   = sig_valid_o & sig_ready_i;
    assign busy_o = state != IDLE;
    assign done_o = done;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and bus/stream outputs; outputs are zero outside their owning state
    always_comb begin
        state_nx    = state;
        host_req_o  = 1'b0;
        host_addr_o = '0;
        sig_valid_o = 1'b0;
        sig_data_o  = '0;
        sig_last_o  = 1'b0;
        case (state)
            IDLE: if (start && run_ok) state_nx = REQ;
            REQ: begin
                host_req_o  = 1'b1;
                host_addr_o = ptr;
                if (host_gnt_i) state_nx = WAIT;
            end
            WAIT: if (host_rvalid_i) state_nx = host_err_i ? IDLE : EMIT;
            EMIT: begin
                sig_valid_o = 1'b1;
                sig_data_o  = data;
                sig_last_o  = last;
                if (sig_ready_i) state_nx = last ? IDLE : REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Register file, device responses and run bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beg_addr     <= '0;
            end_addr     <= '0;
            ptr          <= '0;
            count        <= '0;
            data         <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            dev_rvalid_o <= 1'b0;
            dev_rdata_o  <= '0;
            dev_err_o    <= 1'b0;
        end else begin
            dev_rvalid_o <= dev_req_i;
            dev_err_o    <= dev_req_i & acc_err;
            dev_rdata_o  <= (dev_req_i && !dev_we_i && !acc_err) ? rd_mux : '0;
            if (wr_ok && sel_beg) beg_addr <= (beg_addr & ~wmask) | (dev_wdata_i & wmask);
            if (wr_ok && sel_end) end_addr <= (end_addr & ~wmask) | (dev_wdata_i & wmask);
            if (start) begin
                done  <= ~run_ok;
                err   <= 1'b0;
                count <= '0;
                ptr   <= beg_aln;
            end
            if (state == WAIT && host_rvalid_i) begin
                data <= host_rdata_i;
                if (host_err_i) begin
                    err  <= 1'b1;
                    done <= 1'b1;
                end
            end
            if (fire) begin
                ptr   <= ptr + 32'd4;
                count <= count + 32'd1;
                if (last) done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sig_dump.sv
// tb_sig_dump: randomized scoreboard bench for sig_dump with a RAM/bus responder and stream monitor
module tb_sig_dump;
    localparam int MW = 8;

    logic        clk, rst_ni;
    logic        dev_req_i, dev_we_i;
    logic [31:0] dev_addr_i, dev_wdata_i;
    logic [3:0]  dev_be_i;
    logic        dev_rvalid_o, dev_err_o;
    logic [31:0] dev_rdata_o;
    logic        host_req_o, host_gnt_i, host_rvalid_i, host_err_i;
    logic [31:0] host_addr_o, host_rdata_i;
    logic        sig_valid_o, sig_ready_i, sig_last_o;
    logic [31:0] sig_data_o;
    logic        busy_o, done_o;

    logic [32:0] exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          gnt_fixed = -1;
    int          lat_fixed = -1;
    logic        ready_rand = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    sig_dump #(.AddrWinBits(10), .MaxWords(MW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
        .dev_wdata_i(dev_wdata_i), .dev_be_i(dev_be_i),
        .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
        .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i), .sig_data_o(sig_data_o),
        .sig_last_o(sig_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents seen through the host bus
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a >= 32'h100 && a < 32'h110) ? 32'hA0 + ((a - 32'h100) >> 2)
                                             : (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: list word addresses in [BEGIN&~3, END) capped at MW, cut at the erroring read
    function automatic void model(input logic [31:0] b, input logic [31:0] e, input logic [31:0] ea,
                                  output int n, output logic er);
        longint unsigned a;
        logic [31:0]     addrs[$];
        a = {32'b0, b[31:2], 2'b00};
        while (a < {32'b0, e} && addrs.size() < MW) begin
            addrs.push_back(a[31:0]);
            a += 4;
        end
        n  = 0;
        er = 1'b0;
        for (int i = 0; i < addrs.size(); i++) begin
            if (addrs[i] == ea) begin
                er = 1'b1;
                break;
            end
            exp_q.push_back({1'(i == addrs.size() - 1), ram_word(addrs[i])});
            n++;
        end
    endfunction

    // Host bus responder: optional grant delay, then a read response after a latency
    initial begin
        int          wait_cnt;
        int          resp_cnt;
        logic [31:0] resp_addr;
        wait_cnt = -1;
        resp_cnt = -1;
        resp_addr = '0;
        host_gnt_i = 1'b0;
        host_rvalid_i = 1'b0;
        host_rdata_i = '0;
        host_err_i = 1'b0;
        forever begin
            @(negedge clk);
            host_gnt_i = 1'b0;
            host_rvalid_i = 1'b0;
            host_rdata_i = '0;
            host_err_i = 1'b0;
            if (resp_cnt == 0) begin
                host_rvalid_i = 1'b1;
                host_rdata_i = ram_word(resp_addr);
                host_err_i = resp_addr == err_addr;
                resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end
            if (host_req_o && resp_cnt < 0 && !host_rvalid_i) begin
                if (wait_cnt < 0) wait_cnt = gnt_fixed >= 0 ? gnt_fixed : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    host_gnt_i = 1'b1;
                    resp_addr = host_addr_o;
                    resp_cnt = lat_fixed >= 0 ? lat_fixed : int'($urandom_range(0, 3));
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        sig_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            sig_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability
    initial begin
        logic        pv, pr, phr, phg;
        logic [31:0] pd, pha;
        logic [32:0] e;
        pv = 0; pr = 0; phr = 0; phg = 0; pd = 0; pha = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_ni) begin
                pv = 0;
                phr = 0;
                continue;
            end
            if (!sig_valid_o) chk("idle_stream_zero", {31'b0, sig_last_o, sig_data_o}, 0);
            if (pv && !pr) begin
                chk("sig_hold_valid", sig_valid_o, 1);
                chk("sig_hold_data", sig_data_o, pd);
            end
            if (phr && !phg) begin
                chk("host_hold_req", host_req_o, 1);
                chk("host_hold_addr", host_addr_o, pha);
            end
            if (sig_valid_o && sig_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", sig_data_o, sig_last_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {31'b0, sig_last_o, sig_data_o}, {31'b0, e});
                end
            end
            pv = sig_valid_o; pr = sig_ready_i; pd = sig_data_o;
            phr = host_req_o; phg = host_gnt_i; pha = host_addr_o;
        end
    end

    task automatic dev_acc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           output logic [31:0] rd, output logic er);
        @(negedge clk);
        dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = a; dev_wdata_i = d; dev_be_i = be;
        @(negedge clk);
        dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = '0; dev_wdata_i = '0; dev_be_i = '0;
        #1;
        chk("dev_rvalid", dev_rvalid_o, 1);
        rd = dev_rdata_o;
        er = dev_err_o;
    endtask

    task automatic reg_chk(input string n, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        dev_acc(we, a, d, be, rd, er);
        chk({n, "_err"}, er, exp_er);
        if (!we || exp_er) chk({n, "_rdata"}, rd, exp_rd);
    endtask

    task automatic wait_idle(input string n);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (!busy_o) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL %s: busy_o still 1 after 3000 cycles, expected 0", n);
    endtask

    task automatic start_run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] ea,
                             output int exp_n, output logic exp_er);
        logic [31:0] rd;
        logic        er, ok;
        err_addr = ea;
        reg_chk("wr_begin", 1, 32'h0, b, 4'hF, 0, 0);
        reg_chk("wr_end", 1, 32'h4, e, 4'hF, 0, 0);
        model(b, e, ea, exp_n, exp_er);
        ok = {b[31:2], 2'b00} < e;
        dev_acc(1, 32'h8, 32'h1, 4'h1, rd, er);
        chk("start_err", er, 0);
        chk("start_req_next", host_req_o, ok);
        chk("start_busy", busy_o, ok);
        chk("start_done", done_o, !ok);
    endtask

    task automatic finish_run(input string n, input int exp_n, input logic exp_er);
        wait_idle(n);
        repeat (2) @(negedge clk);
        chk({n, "_drained"}, exp_q.size(), 0);
        chk({n, "_done"}, done_o, 1);
        reg_chk({n, "_count"}, 0, 32'h10, 0, 4'hF, exp_n, 0);
        reg_chk({n, "_status"}, 0, 32'hC, 0, 4'hF, {29'b0, exp_er, 2'b10}, 0);
        exp_q.delete();
    endtask

    task automatic run(input string n, input logic [31:0] b, input logic [31:0] e, input logic [31:0] ea);
        int   en;
        logic eer;
        start_run(b, e, ea, en, eer);
        finish_run(n, en, eer);
    endtask

    initial begin
        int          en;
        logic        eer;
        logic [31:0] b, e, ea;
        rst_ni = 1'b0;
        dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = '0; dev_wdata_i = '0; dev_be_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stream", {sig_valid_o, sig_last_o, sig_data_o}, 0);
        chk("rst_host", {host_req_o, host_addr_o}, 0);
        chk("rst_dev", {dev_rvalid_o, dev_err_o, dev_rdata_o}, 0);
        chk("rst_status", {busy_o, done_o}, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        reg_chk("status_init", 0, 32'hC, 0, 4'hF, 0, 0);
        reg_chk("be_clear", 1, 32'h0, 32'h0, 4'hF, 0, 0);
        reg_chk("be_w0101", 1, 32'h0, 32'hFFFF_FFFF, 4'b0101, 0, 0);
        reg_chk("be_r0101", 0, 32'h0, 0, 4'hF, 32'h00FF_00FF, 0);
        reg_chk("be_w1010", 1, 32'h0, 32'h1234_5678, 4'b1010, 0, 0);
        reg_chk("be_r1010", 0, 32'h0, 0, 4'hF, 32'h12FF_56FF, 0);
        reg_chk("rd_ctrl", 0, 32'h8, 0, 4'hF, 0, 1);
        reg_chk("wr_status", 1, 32'hC, 32'h7, 4'hF, 0, 1);
        reg_chk("wr_count", 1, 32'h10, 32'h5, 4'hF, 0, 1);
        reg_chk("rd_count_after_wr", 0, 32'h10, 0, 4'hF, 0, 0);
        reg_chk("rd_unmapped", 0, 32'h3FC, 0, 4'hF, 0, 1);

        run("basic", 32'h100, 32'h110, 32'hFFFF_FFFF);
        run("empty", 32'h200, 32'h200, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) chk("empty_no_req", host_req_o, 0);

        gnt_fixed = 5;
        ready_rand = 1'b1;
        run("stall", 32'h100, 32'h110, 32'hFFFF_FFFF);
        gnt_fixed = -1;
        ready_rand = 1'b0;

        run("host_err", 32'h100, 32'h110, 32'h104);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("host_err_no_req", host_req_o, 0);
        end

        gnt_fixed = 5;
        start_run(32'h100, 32'h110, 32'hFFFF_FFFF, en, eer);
        reg_chk("busy_wr_begin", 1, 32'h0, 32'h500, 4'hF, 0, 1);
        reg_chk("busy_wr_ctrl", 1, 32'h8, 32'h1, 4'hF, 0, 1);
        reg_chk("busy_rd_begin", 0, 32'h0, 0, 4'hF, 32'h100, 0);
        finish_run("busy_run", en, eer);
        gnt_fixed = -1;
        reg_chk("rd_0x14", 0, 32'h14, 0, 4'hF, 0, 1);

        run("top_of_space", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("unaligned", 32'h301, 32'h309, 32'hFFFF_FFFF);
        run("max_words", 32'h2000, 32'h3000, 32'hFFFF_FFFF);

        for (int i = 0; i < 12; i++) begin
            ready_rand = 1'($urandom_range(0, 1));
            b = 32'h4000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            e = b - 32'd8 + 32'($urandom_range(0, 56));
            ea = ($urandom_range(0, 2) == 0) ? {b[31:2], 2'b00} + 32'($urandom_range(0, 5)) * 4 : 32'hFFFF_FFFF;
            run("random", b, e, ea);
        end
        ready_rand = 1'b0;

        gnt_fixed = 0;
        lat_fixed = 20;
        start_run(32'h100, 32'h110, 32'hFFFF_FFFF, en, eer);
        @(negedge clk);
        #1;
        chk("wait_no_req", host_req_o, 0);
        chk("wait_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_stream", {sig_valid_o, sig_last_o, sig_data_o}, 0);
        chk("midrst_host", {host_req_o, host_addr_o}, 0);
        chk("midrst_status", {busy_o, done_o}, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        exp_q.delete();
        gnt_fixed = -1;
        lat_fixed = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_no_req", host_req_o, 0);
            chk("postrst_no_valid", sig_valid_o, 0);
        end
        reg_chk("postrst_status", 0, 32'hC, 0, 4'hF, 0, 0);
        reg_chk("postrst_begin", 0, 32'h0, 0, 4'hF, 0, 0);
        reg_chk("postrst_end", 0, 32'h4, 0, 4'hF, 0, 0);
        reg_chk("postrst_count", 0, 32'h10, 0, 4'hF, 0, 0);
        run("recover", 32'h100, 32'h110, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
